dvp_camera_emitter: RTL and testbench

Transmit-side counterpart of the camera capture path. Accepts RGB565 pixels over a valid/ready stream and emits an OV5640-style DVP byte stream (vsync, href, 8-bit data, two bytes per pixel) with parameterised frame timing. Used to loop processed frames back into the capture input for self-test, and to drive an external DVP sink. Byte packing is the exact inverse of the capture path, so a capture → emit → capture round trip is bit-exact.

---
 rtl/dvp_tx_pkg.sv | 31 +++
 rtl/dvp_tx_timing.sv | 137 +++++++++++++
 rtl/dvp_camera_emitter.sv | 139 +++++++++++++
 tb/tb_dvp_camera_emitter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_tx_pkg.sv
// Shared types and helpers for the DVP transmit path: state encoding,
// RGB565 <-> DVP word packing and counter sizing.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } dvp_state_e;

    // Swaps the 5-bit R and B fields around G; applying it twice restores the pixel.
    function automatic logic [15:0] rgb565_to_dvp_word(input logic [15:0] pix);
        return {pix[4:0], pix[10:5], pix[15:11]};
    endfunction

    function automatic int h_cnt_width(input int h_active, input int h_blank);
        int len;
        len = 32'd2 * h_active + h_blank;
        return (len > 32'd1) ? $clog2(len) : 32'd1;
    endfunction

    function automatic int line_cnt_width(input int v_active, input int vsync_lines,
                                          input int vbp_lines, input int vfp_lines);
        int total;
        total = v_active + vsync_lines + vbp_lines + vfp_lines;
        return (total > 32'd1) ? $clog2(total) : 32'd1;
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Frame timing generator: region state machine, horizontal and per-region line
// counters, and decoded strobes describing the current byte slot.
module dvp_tx_timing
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic i_clk_pixel,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_slot_active,
    output logic o_slot_even,
    output logic o_first_slot,
    output logic o_vsync,
    output logic o_frame_start
);

    localparam int LINE_LEN = 32'd2 * H_ACTIVE + H_BLANK;
    localparam int H_W      = h_cnt_width(H_ACTIVE, H_BLANK);
    localparam int LN_W     = line_cnt_width(V_ACTIVE, VSYNC_LINES, VBP_LINES, VFP_LINES);

    localparam logic [H_W-1:0]  H_ZERO      = H_W'(32'd0);
    localparam logic [H_W-1:0]  H_ONE       = H_W'(32'd1);
    localparam logic [H_W-1:0]  H_LAST      = H_W'(LINE_LEN - 32'd1);
    localparam logic [H_W-1:0]  H_ACT_END   = H_W'(32'd2 * H_ACTIVE);
    localparam logic [LN_W-1:0] LN_ZERO     = LN_W'(32'd0);
    localparam logic [LN_W-1:0] LN_ONE      = LN_W'(32'd1);
    localparam logic [LN_W-1:0] VSYNC_LAST  = LN_W'(VSYNC_LINES - 32'd1);
    localparam logic [LN_W-1:0] VBP_LAST    = LN_W'(VBP_LINES - 32'd1);
    localparam logic [LN_W-1:0] ACTIVE_LAST = LN_W'(V_ACTIVE - 32'd1);
    localparam logic [LN_W-1:0] VFP_LAST    = LN_W'(VFP_LINES - 32'd1);

    dvp_state_e      state_r;
    dvp_state_e      state_nxt_s;
    dvp_state_e      next_region_s;
    logic [H_W-1:0]  h_r;
    logic [H_W-1:0]  h_nxt_s;
    logic [LN_W-1:0] line_r;
    logic [LN_W-1:0] line_nxt_s;
    logic [LN_W-1:0] region_last_s;

    // Last line index of the current region and the region that follows it.
    always_comb begin
        region_last_s = LN_ZERO;
        next_region_s = ST_IDLE;
        case (state_r)
            ST_VSYNC: begin
                region_last_s = VSYNC_LAST;
                next_region_s = ST_VBP;
            end
            ST_VBP: begin
                region_last_s = VBP_LAST;
                next_region_s = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                region_last_s = ACTIVE_LAST;
                next_region_s = ST_VFP;
            end
            ST_VFP: begin
                region_last_s = VFP_LAST;
                if (i_enable) begin
                    next_region_s = ST_VSYNC;
                end else begin
                    next_region_s = ST_IDLE;
                end
            end
            default: begin
                region_last_s = LN_ZERO;
                next_region_s = ST_IDLE;
            end
        endcase
    end

    // Counter advance; a region only changes on the wrap of its last line.
    always_comb begin
        state_nxt_s = state_r;
        h_nxt_s     = h_r;
        line_nxt_s  = line_r;
        case (state_r)
            ST_IDLE: begin
                h_nxt_s    = H_ZERO;
                line_nxt_s = LN_ZERO;
                if (i_enable) begin
                    state_nxt_s = ST_VSYNC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP: begin
                if (h_r == H_LAST) begin
                    h_nxt_s = H_ZERO;
                    if (line_r == region_last_s) begin
                        line_nxt_s  = LN_ZERO;
                        state_nxt_s = next_region_s;
                    end else begin
                        line_nxt_s  = line_r + LN_ONE;
                    end
                end else begin
                    h_nxt_s = h_r + H_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                h_nxt_s     = H_ZERO;
                line_nxt_s  = LN_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            h_r     <= H_ZERO;
            line_r  <= LN_ZERO;
        end else begin
            state_r <= state_nxt_s;
            h_r     <= h_nxt_s;
            line_r  <= line_nxt_s;
        end
    end

    // Slot decodes for the current cycle; the top level registers them onto the pins.
    always_comb begin
        o_slot_active = (state_r == ST_ACTIVE) && (h_r < H_ACT_END);
        o_slot_even   = ~h_r[0];
        o_first_slot  = (state_r == ST_ACTIVE) && (line_r == LN_ZERO) && (h_r == H_ZERO);
        o_vsync       = (state_r == ST_VSYNC);
        o_frame_start = (state_r == ST_VBP) && (line_r == LN_ZERO) && (h_r == H_ZERO);
    end

endmodule

// File: rtl/dvp_camera_emitter.sv
// RGB565 stream to DVP byte stream emitter: one-pixel holding register,
// two-byte-per-pixel output mux and sticky underflow / sync error flags.
module dvp_camera_emitter
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic        i_clk_pixel,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_clear_flags,
    input  logic        i_rgb565_valid,
    input  logic        i_rgb565_sof,
    input  logic [15:0] i_rgb565_data,
    output logic        o_rgb565_ready,
    output logic        o_camera_vsync,
    output logic        o_camera_hsync,
    output logic [7:0]  o_camera_data,
    output logic        o_frame_start,
    output logic        o_underflow,
    output logic        o_sync_err
);

    logic        slot_active_s;
    logic        slot_even_s;
    logic        first_slot_s;
    logic        vsync_s;
    logic        frame_start_s;
    logic        consume_s;
    logic        accept_s;
    logic        underflow_set_s;
    logic        sync_err_set_s;
    logic [15:0] packed_s;

    logic        hold_valid_r;
    logic        hold_sof_r;
    logic [15:0] hold_data_r;
    logic [7:0]  lo_byte_r;
    logic [7:0]  data_r;
    logic        vsync_r;
    logic        hsync_r;
    logic        frame_start_r;
    logic        underflow_r;
    logic        sync_err_r;

    dvp_tx_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES),
        .VFP_LINES   (VFP_LINES)
    ) u_timing (
        .i_clk_pixel   (i_clk_pixel),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .o_slot_active (slot_active_s),
        .o_slot_even   (slot_even_s),
        .o_first_slot  (first_slot_s),
        .o_vsync       (vsync_s),
        .o_frame_start (frame_start_s)
    );

    // Handshake and fault detection for the slot being emitted this cycle.
    always_comb begin
        consume_s       = slot_active_s && slot_even_s;
        o_rgb565_ready  = !hold_valid_r || consume_s;
        accept_s        = i_rgb565_valid && o_rgb565_ready;
        packed_s        = rgb565_to_dvp_word(hold_data_r);
        underflow_set_s = consume_s && !hold_valid_r;
        if (consume_s && hold_valid_r) begin
            sync_err_set_s = first_slot_s ? !hold_sof_r : hold_sof_r;
        end else begin
            sync_err_set_s = 1'b0;
        end
    end

    // Holding register; a new pixel may land in the same cycle the old one leaves.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            hold_valid_r <= 1'b0;
            hold_sof_r   <= 1'b0;
            hold_data_r  <= 16'h0000;
        end else if (accept_s) begin
            hold_valid_r <= 1'b1;
            hold_sof_r   <= i_rgb565_sof;
            hold_data_r  <= i_rgb565_data;
        end else if (consume_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Pin registers; the low byte is captured at consume so the hold slot frees early.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            vsync_r       <= 1'b0;
            hsync_r       <= 1'b0;
            frame_start_r <= 1'b0;
            data_r        <= 8'h00;
            lo_byte_r     <= 8'h00;
        end else begin
            vsync_r       <= vsync_s;
            hsync_r       <= slot_active_s;
            frame_start_r <= frame_start_s;
            if (consume_s) begin
                data_r    <= hold_valid_r ? packed_s[15:8] : 8'h00;
                lo_byte_r <= hold_valid_r ? packed_s[7:0]  : 8'h00;
            end else if (slot_active_s) begin
                data_r    <= lo_byte_r;
            end else begin
                data_r    <= 8'h00;
            end
        end
    end

    // Sticky flags; a fault in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            underflow_r <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            underflow_r <= underflow_set_s || (underflow_r && !i_clear_flags);
            sync_err_r  <= sync_err_set_s  || (sync_err_r  && !i_clear_flags);
        end
    end

    assign o_camera_vsync = vsync_r;
    assign o_camera_hsync = hsync_r;
    assign o_camera_data  = data_r;
    assign o_frame_start  = frame_start_r;
    assign o_underflow    = underflow_r;
    assign o_sync_err     = sync_err_r;

endmodule

// File: tb/tb_dvp_camera_emitter.sv
// Directed bench for dvp_camera_emitter on a tiny 4x2 frame (11-cycle lines, 55-cycle frames).
module tb_dvp_camera_emitter;

    localparam int H_ACTIVE    = 4;
    localparam int V_ACTIVE    = 2;
    localparam int H_BLANK     = 3;
    localparam int VSYNC_LINES = 1;
    localparam int VBP_LINES   = 1;
    localparam int VFP_LINES   = 1;
    localparam int FRAME       = 55;
    localparam int LOG_N       = 1024;

    localparam int B_VS  = 0;
    localparam int B_HS  = 1;
    localparam int B_FS  = 2;
    localparam int B_UF  = 3;
    localparam int B_SE  = 4;
    localparam int B_RDY = 5;

    logic        i_clk_pixel = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic        i_clear_flags;
    logic        i_rgb565_valid;
    logic        i_rgb565_sof;
    logic [15:0] i_rgb565_data;
    logic        o_rgb565_ready;
    logic        o_camera_vsync;
    logic        o_camera_hsync;
    logic [7:0]  o_camera_data;
    logic        o_frame_start;
    logic        o_underflow;
    logic        o_sync_err;

    dvp_camera_emitter #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES),
        .VFP_LINES   (VFP_LINES)
    ) dut (
        .i_clk_pixel    (i_clk_pixel),
        .i_rst          (i_rst),
        .i_enable       (i_enable),
        .i_clear_flags  (i_clear_flags),
        .i_rgb565_valid (i_rgb565_valid),
        .i_rgb565_sof   (i_rgb565_sof),
        .i_rgb565_data  (i_rgb565_data),
        .o_rgb565_ready (o_rgb565_ready),
        .o_camera_vsync (o_camera_vsync),
        .o_camera_hsync (o_camera_hsync),
        .o_camera_data  (o_camera_data),
        .o_frame_start  (o_frame_start),
        .o_underflow    (o_underflow),
        .o_sync_err     (o_sync_err)
    );

    always #5 i_clk_pixel = ~i_clk_pixel;

    int          n_vec = 0;
    int          n_err = 0;
    int          k     = 0;
    int          base  = 0;
    logic [16:0] pix_q[$];
    logic [15:0] sent[0:7];
    logic [7:0]  exp_b[0:15];
    logic [5:0]  pin_log[0:LOG_N-1];
    logic [7:0]  dat_log[0:LOG_N-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_stream();
        if (pix_q.size() > 0) begin
            i_rgb565_valid = 1'b1;
            i_rgb565_sof   = pix_q[0][16];
            i_rgb565_data  = pix_q[0][15:0];
        end else begin
            i_rgb565_valid = 1'b0;
            i_rgb565_sof   = 1'b0;
            i_rgb565_data  = 16'h0000;
        end
    endtask

    // One clock: pop the pixel if it was handshaken, refresh inputs, log the pins.
    task automatic tick();
        logic acc;
        acc = i_rgb565_valid && o_rgb565_ready;
        @(posedge i_clk_pixel);
        #1;
        if (acc) void'(pix_q.pop_front());
        i_clear_flags = 1'b0;
        drive_stream();
        k++;
        if (k < LOG_N) begin
            pin_log[k] = {o_rgb565_ready, o_sync_err, o_underflow,
                          o_frame_start, o_camera_hsync, o_camera_vsync};
            dat_log[k] = o_camera_data;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int count_bit(input int b, input int a, input int z);
        int c;
        c = 0;
        for (int i = a; i <= z; i++) if (pin_log[i][b]) c++;
        return c;
    endfunction

    function automatic logic [15:0] pack_model(input logic [15:0] p);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = p[15:11];
        g = p[10:5];
        b = p[4:0];
        return {b, g[5:3], g[2:0], r};
    endfunction

    task automatic fill_expected(input int nvalid);
        logic [15:0] w;
        for (int j = 0; j < 8; j++) begin
            w = (j < nvalid) ? pack_model(sent[j]) : 16'h0000;
            exp_b[2*j]   = w[15:8];
            exp_b[2*j+1] = w[7:0];
        end
    endtask

    task automatic check_capture(input int fb, input string tag);
        logic [7:0] got[$];
        for (int i = fb + 22; i <= fb + 43; i++) if (pin_log[i][B_HS]) got.push_back(dat_log[i]);
        check_val({tag, "_nbytes"}, got.size(), 16);
        for (int j = 0; j < 16; j++) begin
            if (j < got.size()) check_val($sformatf("%s_byte%0d", tag, j), got[j], exp_b[j]);
        end
    endtask

    // Rebuilds pixels the way the capture path does: {hi, lo} then the R/B field swap.
    task automatic check_roundtrip(input int fb, input string tag);
        logic [7:0]  got[$];
        logic [15:0] w;
        for (int i = fb + 22; i <= fb + 43; i++) if (pin_log[i][B_HS]) got.push_back(dat_log[i]);
        check_val({tag, "_nbytes"}, got.size(), 16);
        if (got.size() >= 16) begin
            for (int j = 0; j < 8; j++) begin
                w = {got[2*j], got[2*j+1]};
                check_val($sformatf("%s_pix%0d", tag, j), {w[4:0], w[10:5], w[15:11]}, sent[j]);
            end
        end
    endtask

    initial begin
        logic [7:0] pk_tab[0:3];
        int         s;
        pk_tab = '{8'h00, 8'h1F, 8'h07, 8'hE0};
        i_rst = 1'b1; i_enable = 1'b1; i_clear_flags = 1'b0;
        i_rgb565_valid = 1'b0; i_rgb565_sof = 1'b0; i_rgb565_data = 16'h0000;

        // Reset with enable already high
        run(3);
        check_val("reset_pins", {26'd0, pin_log[k]}, 32'h20);
        check_val("reset_data", dat_log[k], 32'h0);

        // Frame 0: alternating red / green, sof on the first pixel
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sent[i] = (i % 2 == 0) ? 16'hF800 : 16'h07E0;
            pix_q.push_back({(i == 0), sent[i]});
        end
        drive_stream();
        tick();
        base = k + 1;
        run(FRAME);
        check_val("vs_before", pin_log[base-1][B_VS], 32'h0);
        check_val("vs_len", count_bit(B_VS, base, base + 10), 11);
        check_val("vs_after", pin_log[base+11][B_VS], 32'h0);
        check_val("fs_pos", pin_log[base+11][B_FS], 32'h1);
        check_val("fs_count", count_bit(B_FS, base, base + 54), 1);
        check_val("href_line0", count_bit(B_HS, base + 22, base + 29), 8);
        check_val("href_gap", count_bit(B_HS, base + 30, base + 32), 0);
        check_val("href_line1", count_bit(B_HS, base + 33, base + 40), 8);
        for (int j = 0; j < 16; j++) exp_b[j] = pk_tab[j % 4];
        check_capture(base, "pack");
        check_val("pack_flags", {pin_log[base+54][B_UF], pin_log[base+54][B_SE]}, 32'h0);

        // Frame 1: only three pixels
        base = base + FRAME;
        sent[0] = 16'hFFFF; sent[1] = 16'h001F; sent[2] = 16'hF81F;
        for (int i = 0; i < 3; i++) pix_q.push_back({(i == 0), sent[i]});
        drive_stream();
        run(FRAME);
        fill_expected(3);
        check_capture(base, "uflow");
        check_val("uflow_pre", pin_log[base+27][B_UF], 32'h0);
        check_val("uflow_set", pin_log[base+28][B_UF], 32'h1);
        check_val("uflow_sticky", pin_log[base+54][B_UF], 32'h1);
        check_val("uflow_no_se", pin_log[base+54][B_SE], 32'h0);

        // Frame 2: clear flags, then a frame whose first pixel lacks sof
        base = base + FRAME;
        i_clear_flags = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sent[i] = 16'h1234 + 16'(i) * 16'h1111;
            pix_q.push_back({1'b0, sent[i]});
        end
        drive_stream();
        run(FRAME);
        check_val("clear_uflow", pin_log[base][B_UF], 32'h0);
        check_val("se_nosof_pre", pin_log[base+21][B_SE], 32'h0);
        check_val("se_nosof_set", pin_log[base+22][B_SE], 32'h1);
        fill_expected(8);
        check_capture(base, "nosof");

        // Frame 3: sof on the first and the third pixel
        base = base + FRAME;
        i_clear_flags = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sent[i] = 16'hA5C3 + 16'(i) * 16'h0101;
            pix_q.push_back({(i == 0 || i == 2), sent[i]});
        end
        drive_stream();
        run(FRAME);
        check_val("se_clear", pin_log[base][B_SE], 32'h0);
        check_val("se_midsof_pre", pin_log[base+25][B_SE], 32'h0);
        check_val("se_midsof_set", pin_log[base+26][B_SE], 32'h1);
        fill_expected(8);
        check_capture(base, "midsof");

        // Frame 4: continuous valid, next frame's first pixel queued behind, enable drops mid-ACTIVE
        base = base + FRAME;
        i_clear_flags = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sent[i] = 16'(i + 1) * 16'h0F1E;
            pix_q.push_back({(i == 0), sent[i]});
        end
        pix_q.push_back({1'b1, 16'h5A5A});
        drive_stream();
        for (int i = 0; i < FRAME + 8; i++) begin
            if (k == base + 30) i_enable = 1'b0;
            tick();
        end
        begin
            int pairs;
            pairs = 0;
            for (int i = base + 21; i < base + 42; i++)
                if (pin_log[i][B_RDY] && pin_log[i+1][B_RDY]) pairs++;
            check_val("bp_ready_count", count_bit(B_RDY, base + 21, base + 42), 8);
            check_val("bp_ready_pairs", pairs, 0);
        end
        check_roundtrip(base, "bp");
        check_val("bp_flags", {pin_log[base+54][B_UF], pin_log[base+54][B_SE]}, 32'h0);
        check_val("drop_line1", count_bit(B_HS, base + 33, base + 40), 8);
        check_val("drop_vfp_vs", count_bit(B_VS, base + 44, base + 54), 0);
        check_val("idle_vs", count_bit(B_VS, base + 55, base + 62), 0);
        check_val("idle_hs", count_bit(B_HS, base + 55, base + 62), 0);
        check_val("idle_fs", count_bit(B_FS, base + 55, base + 62), 0);

        // Frame 5: re-enable; the preloaded sof pixel leads the frame
        i_enable = 1'b1;
        sent[0] = 16'h5A5A;
        for (int i = 1; i < 8; i++) begin
            sent[i] = 16'hC000 + 16'(i);
            pix_q.push_back({1'b0, sent[i]});
        end
        drive_stream();
        s = k;
        base = s + 2;
        run(56);
        check_val("reen_vs_first", pin_log[s+1][B_VS], 32'h0);
        check_val("reen_vs_len", count_bit(B_VS, base, base + 10), 11);
        check_val("reen_fs", pin_log[base+11][B_FS], 32'h1);
        check_roundtrip(base, "reen");
        check_val("reen_flags", {pin_log[base+54][B_UF], pin_log[base+54][B_SE]}, 32'h0);

        // Reset in the middle of an underflowing frame
        run(25);
        check_val("mid_hs", pin_log[k][B_HS], 32'h1);
        check_val("mid_uflow", pin_log[k][B_UF], 32'h1);
        pix_q.delete();
        drive_stream();
        i_rst = 1'b1;
        tick();
        check_val("midrst_pins", {26'd0, pin_log[k]}, 32'h20);
        check_val("midrst_data", dat_log[k], 32'h0);
        i_rst = 1'b0;
        i_enable = 1'b0;
        run(3);
        check_val("post_rst_vs", count_bit(B_VS, k - 2, k), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
